// File: rtl/alu_seq_if.sv
// Instruction handshake and completion bus between an issuing agent and alu_seq.
interface alu_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        done;
   logic [4:0]  done_rd;
   logic [31:0] done_data;
   logic        done_illegal;

   modport master (
      output in_valid, in_instr,
      input  in_ready, done, done_rd, done_data, done_illegal
   );

   modport slave (
      input  in_valid, in_instr,
      output in_ready, done, done_rd, done_data, done_illegal
   );
endinterface

// File: rtl/alu_seq.sv
// Three-phase RV32I ALU sequencer (IDLE/EXEC/WB) driving an external combinational
// ALU and owning a 32x32 register file.
module alu_seq (
   input  logic        clk,
   input  logic        rst_n,
   alu_seq_if.slave    bus,
   output logic [2:0]  alu_opcode,
   output logic [31:0] alu_left,
   output logic [31:0] alu_right,
   input  logic [31:0] alu_result,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_WB   = 2'b10
   } state_e;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_AND = 3'b111;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b001;

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;

   state_e      state_q, state_d;
   logic [2:0]  alu_op_q, alu_op_d;
   logic [31:0] alu_left_q, alu_left_d;
   logic [31:0] alu_right_q, alu_right_d;
   logic [4:0]  rd_q, rd_d;
   logic        ill_q, ill_d;
   logic        done_q, done_d;
   logic [4:0]  done_rd_q, done_rd_d;
   logic [31:0] done_data_q, done_data_d;
   logic        done_ill_q, done_ill_d;
   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   logic [6:0]  opc_s;
   logic [2:0]  f3_s;
   logic [6:0]  f7_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [31:0] imm_s;
   logic [2:0]  dec_op_s;
   logic        dec_ill_s;

   assign opc_s = bus.in_instr[6:0];
   assign f3_s  = bus.in_instr[14:12];
   assign f7_s  = bus.in_instr[31:25];
   assign rs1_s = bus.in_instr[19:15];
   assign rs2_s = bus.in_instr[24:20];
   assign imm_s = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};

   // Instruction decode of the word currently offered on the bus.
   always_comb begin
      dec_op_s  = OP_ADD;
      dec_ill_s = 1'b1;
      case (opc_s)
         OPC_R: begin
            case (f3_s)
               3'b000: begin
                  dec_op_s  = bus.in_instr[30] ? OP_SUB : OP_ADD;
                  dec_ill_s = !((f7_s == 7'b0000000) || (f7_s == 7'b0100000));
               end
               3'b111: begin dec_op_s = OP_AND; dec_ill_s = (f7_s != 7'b0000000); end
               3'b110: begin dec_op_s = OP_OR;  dec_ill_s = (f7_s != 7'b0000000); end
               3'b100: begin dec_op_s = OP_XOR; dec_ill_s = (f7_s != 7'b0000000); end
               default: dec_ill_s = 1'b1;
            endcase
         end
         OPC_I: begin
            case (f3_s)
               3'b000: begin dec_op_s = OP_ADD; dec_ill_s = 1'b0; end
               3'b111: begin dec_op_s = OP_AND; dec_ill_s = 1'b0; end
               3'b110: begin dec_op_s = OP_OR;  dec_ill_s = 1'b0; end
               3'b100: begin dec_op_s = OP_XOR; dec_ill_s = 1'b0; end
               default: dec_ill_s = 1'b1;
            endcase
         end
         default: dec_ill_s = 1'b1;
      endcase
   end

   // Sequencer next-state, operand capture, completion and write-back.
   always_comb begin
      state_d     = state_q;
      alu_op_d    = 3'b000;
      alu_left_d  = 32'd0;
      alu_right_d = 32'd0;
      rd_d        = rd_q;
      ill_d       = ill_q;
      done_d      = 1'b0;
      done_rd_d   = 5'd0;
      done_data_d = 32'd0;
      done_ill_d  = 1'b0;
      regs_d      = regs_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d = ST_EXEC;
               rd_d    = bus.in_instr[11:7];
               ill_d   = dec_ill_s;
               // Operands are latched at accept so the ALU sees them for the whole EXEC cycle.
               if (!dec_ill_s) begin
                  alu_op_d    = dec_op_s;
                  alu_left_d  = regs_q[rs1_s];
                  alu_right_d = (opc_s == OPC_R) ? regs_q[rs2_s] : imm_s;
               end else begin
                  alu_op_d = 3'b000;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_d     = ST_WB;
            done_d      = 1'b1;
            done_rd_d   = rd_q;
            done_ill_d  = ill_q;
            done_data_d = ill_q ? 32'd0 : alu_result;
         end
         ST_WB: begin
            state_d = ST_IDLE;
            if (!done_ill_q && (done_rd_q != 5'd0)) begin
               regs_d[done_rd_q] = done_data_q;
            end else begin
               regs_d = regs_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, outputs and register file; reset aborts any in-flight instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         alu_op_q    <= 3'b000;
         alu_left_q  <= 32'd0;
         alu_right_q <= 32'd0;
         rd_q        <= 5'd0;
         ill_q       <= 1'b0;
         done_q      <= 1'b0;
         done_rd_q   <= 5'd0;
         done_data_q <= 32'd0;
         done_ill_q  <= 1'b0;
         regs_q      <= '{default: 32'd0};
      end else begin
         state_q     <= state_d;
         alu_op_q    <= alu_op_d;
         alu_left_q  <= alu_left_d;
         alu_right_q <= alu_right_d;
         rd_q        <= rd_d;
         ill_q       <= ill_d;
         done_q      <= done_d;
         done_rd_q   <= done_rd_d;
         done_data_q <= done_data_d;
         done_ill_q  <= done_ill_d;
         regs_q      <= regs_d;
      end
   end

   assign bus.in_ready     = (state_q == ST_IDLE);
   assign bus.done         = done_q;
   assign bus.done_rd      = done_rd_q;
   assign bus.done_data    = done_data_q;
   assign bus.done_illegal = done_ill_q;
   assign alu_opcode       = alu_op_q;
   assign alu_left         = alu_left_q;
   assign alu_right        = alu_right_q;
   // x0 is never written, so a plain read already returns zero for it.
   assign dbg_data         = regs_q[dbg_addr];

endmodule
